// File: rtl/audio_channel_arbiter_pkg.sv
// Shared types and constants for the audio channel arbiter.
//   arb_state_e : arbiter sequencing states
//   ATTEN_W     : width of the attenuation (right-shift) counter
//   ATTEN_MUTE  : attenuation value that means "fully muted"
package audio_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FADE_IN  = 3'd1,
        PLAY     = 3'd2,
        FADE_OUT = 3'd3,
        SWITCH   = 3'd4
    } arb_state_e;

    localparam int ATTEN_W = 4;
    localparam logic [ATTEN_W-1:0] ATTEN_MUTE = 4'd8;

endpackage

// File: rtl/audio_channel_arbiter_if.sv
// Bus between the audio sources / sample strobe and the arbiter.
//   master : drives sample_valid_in, req_in, prio_mode_in, audio_in
//   slave  : the arbiter; drives audio_out, audio_valid_out, grant_out, busy_out
interface audio_channel_arbiter_if #(
    parameter int NUM_SRC  = 4,
    parameter int SAMPLE_W = 8
);
    logic                         sample_valid_in;
    logic [NUM_SRC-1:0]           req_in;
    logic                         prio_mode_in;
    logic [NUM_SRC*SAMPLE_W-1:0]  audio_in;
    logic signed [SAMPLE_W-1:0]   audio_out;
    logic                         audio_valid_out;
    logic [NUM_SRC-1:0]           grant_out;
    logic                         busy_out;

    modport master (
        output sample_valid_in, req_in, prio_mode_in, audio_in,
        input  audio_out, audio_valid_out, grant_out, busy_out
    );

    modport slave (
        input  sample_valid_in, req_in, prio_mode_in, audio_in,
        output audio_out, audio_valid_out, grant_out, busy_out
    );
endinterface

// File: rtl/audio_channel_arbiter_picker.sv
// Combinational requester picker.
//   req_i    : request vector
//   base_i   : round-robin search start index
//   mode_i   : 0 = lowest index wins, 1 = search from base_i with wrap
//   onehot_o : one-hot winner (zero when nothing requests)
//   idx_o    : winner index
//   found_o  : a winner exists
module rr_priority_picker #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   base_i,
    input  logic               mode_i,
    output logic [NUM_SRC-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    // First requester in search order wins; the search index wraps at NUM_SRC.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [IDX_W:0]   raw;
            logic [IDX_W-1:0] cand;
            raw  = {1'b0, base_i} + (IDX_W+1)'(k);
            cand = mode_i ? ((raw >= (IDX_W+1)'(NUM_SRC)) ? IDX_W'(raw - (IDX_W+1)'(NUM_SRC))
                                                          : IDX_W'(raw))
                          : IDX_W'(k);
            if (!found_o && req_i[cand]) begin
                found_o        = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/audio_channel_arbiter.sv
// Speaker-path arbiter: grants one of NUM_SRC signed sample sources by fixed
// priority or round-robin, enforces a minimum play time before preemption and
// sequences every source change as fade-out -> one silent sample -> fade-in.
//   clk_in : audio clock          rst_in : async active-low reset
//   bus    : audio_channel_arbiter_if.slave (strobe, requests, samples, outputs)
module audio_channel_arbiter
    import audio_arb_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int SAMPLE_W = 8,
    parameter int MIN_HOLD = 1200
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    audio_channel_arbiter_if.slave  bus
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);

    arb_state_e                 state_q, state_d;
    logic [NUM_SRC-1:0]         grant_q, grant_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ATTEN_W-1:0]         atten_q, atten_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    logic signed [SAMPLE_W-1:0] audio_q, audio_d;
    logic                       busy_q, busy_d;
    logic                       valid_q;

    logic signed [SAMPLE_W-1:0] src_s [NUM_SRC];
    logic [NUM_SRC-1:0]         win_onehot_s, pre_onehot_s;
    logic [IDX_W-1:0]           win_idx_s, pre_idx_s;
    logic                       win_found_s, pre_found_s;
    logic                       preempt_s, granted_req_s;
    logic [ATTEN_W-1:0]         atten_up_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_s[g] = bus.audio_in[g*SAMPLE_W +: SAMPLE_W];
    end

    rr_priority_picker #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_load_pick (
        .req_i    (bus.req_in),
        .base_i   (rr_q),
        .mode_i   (bus.prio_mode_in),
        .onehot_o (win_onehot_s),
        .idx_o    (win_idx_s),
        .found_o  (win_found_s)
    );

    // Preemption search excludes the current source; in fixed mode the best
    // remaining requester only counts if it outranks (has a lower index than) us.
    rr_priority_picker #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pre_pick (
        .req_i    (bus.req_in & ~grant_q),
        .base_i   (rr_q),
        .mode_i   (bus.prio_mode_in),
        .onehot_o (pre_onehot_s),
        .idx_o    (pre_idx_s),
        .found_o  (pre_found_s)
    );

    assign preempt_s     = bus.prio_mode_in ? pre_found_s
                                            : ((pre_onehot_s != '0) && (pre_idx_s < idx_q));
    assign granted_req_s = |(bus.req_in & grant_q);
    // Fade-out step saturates at mute so a drop right after a grant load goes straight to SWITCH.
    assign atten_up_s    = (atten_q == ATTEN_MUTE) ? ATTEN_MUTE : atten_q + 4'd1;

    // State and datapath registers; everything but the valid pulse advances only on a strobe.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            atten_q <= ATTEN_MUTE;
            hold_q  <= '0;
            rr_q    <= '0;
            audio_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.sample_valid_in;
            if (bus.sample_valid_in) begin
                state_q <= state_d;
                grant_q <= grant_d;
                idx_q   <= idx_d;
                atten_q <= atten_d;
                hold_q  <= hold_d;
                rr_q    <= rr_d;
                audio_q <= audio_d;
                busy_q  <= busy_d;
            end
        end
    end

    // Next-state logic: arbitration, hold timing and fade sequencing.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        atten_d = atten_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE, SWITCH: begin
                grant_d = '0;
                if (win_found_s) begin
                    grant_d = win_onehot_s;
                    idx_d   = win_idx_s;
                    atten_d = ATTEN_MUTE;
                    state_d = FADE_IN;
                    rr_d    = (win_idx_s == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx_s + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FADE_IN: begin
                if (!granted_req_s) begin
                    atten_d = atten_up_s;
                    state_d = (atten_up_s == ATTEN_MUTE) ? SWITCH : FADE_OUT;
                end else begin
                    atten_d = atten_q - 4'd1;
                    if (atten_q == 4'd1) begin
                        state_d = PLAY;
                        hold_d  = '0;
                    end else begin
                        state_d = FADE_IN;
                    end
                end
            end
            PLAY: begin
                if (!granted_req_s || ((hold_q == HOLD_W'(MIN_HOLD)) && preempt_s)) begin
                    atten_d = atten_up_s;
                    state_d = FADE_OUT;
                end else begin
                    hold_d = (hold_q == HOLD_W'(MIN_HOLD)) ? hold_q : hold_q + 1'b1;
                end
            end
            FADE_OUT: begin
                atten_d = atten_up_s;
                state_d = (atten_up_s == ATTEN_MUTE) ? SWITCH : FADE_OUT;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                atten_d = ATTEN_MUTE;
            end
        endcase
    end

    // Output logic: faded sample of the next grant, and busy for transitional states.
    always_comb begin
        if ((atten_d == ATTEN_MUTE) || (grant_d == '0)) begin
            audio_d = '0;
        end else begin
            audio_d = src_s[idx_d] >>> atten_d;
        end
        busy_d = (state_d == FADE_IN) || (state_d == FADE_OUT) || (state_d == SWITCH);
    end

    assign bus.audio_out       = audio_q;
    assign bus.audio_valid_out = valid_q;
    assign bus.grant_out       = grant_q;
    assign bus.busy_out        = busy_q;

endmodule

// File: tb/tb_audio_channel_arbiter.sv
module tb_audio_channel_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    localparam int PH_QUIET = 0;
    localparam int PH_RISE  = 1;
    localparam int PH_FULL  = 2;
    localparam int PH_FALL  = 3;
    localparam int PH_GAP   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_channel_arbiter_if #(.NUM_SRC(N), .SAMPLE_W(W)) bus ();

    audio_channel_arbiter #(.NUM_SRC(N), .SAMPLE_W(W), .MIN_HOLD(MH)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  cur_req  = 4'd0;
    logic        cur_mode = 1'b0;
    logic [31:0] cur_aud  = 32'd0;

    // Reference model: which source is audible and how loud (gain 0 = silent .. 8 = full).
    int m_src, m_gain, m_phase, m_held, m_ptr;

    typedef struct {
        logic [3:0] req;
        logic [7:0] a0;
        int         out;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input logic mode, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = mode ? (ptr + k) % N : k;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit rival(input logic [3:0] r, input logic mode, input int src);
        for (int j = 0; j < N; j++)
            if (j != src && r[j] && (mode || j < src)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_src = -1; m_gain = 0; m_phase = PH_QUIET; m_held = 0; m_ptr = 0;
    endtask

    task automatic m_start(input logic [3:0] r, input logic mode);
        m_src   = pick(r, mode, m_ptr);
        m_ptr   = (m_src + 1) % N;
        m_gain  = 0;
        m_phase = PH_RISE;
    endtask

    task automatic m_fall();
        if (m_gain > 0) m_gain--;
        m_phase = (m_gain == 0) ? PH_GAP : PH_FALL;
    endtask

    task automatic model_step(input logic [3:0] r, input logic mode);
        case (m_phase)
            PH_QUIET: if (r != 4'd0) m_start(r, mode);
            PH_RISE: begin
                if (!r[m_src]) m_fall();
                else begin
                    m_gain++;
                    if (m_gain == 8) begin m_phase = PH_FULL; m_held = 0; end
                end
            end
            PH_FULL: begin
                if (!r[m_src] || (m_held == MH && rival(r, mode, m_src))) m_fall();
                else if (m_held < MH) m_held++;
            end
            PH_FALL: m_fall();
            default: begin
                m_src = -1;
                if (r != 4'd0) m_start(r, mode);
                else m_phase = PH_QUIET;
            end
        endcase
    endtask

    function automatic int m_out(input logic [31:0] aud);
        int s;
        if (m_src < 0 || m_gain == 0) return 0;
        s = int'($signed(aud[m_src*8 +: 8]));
        return s >>> (8 - m_gain);
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_out"},   int'($signed(bus.audio_out)), m_out(cur_aud));
        chk({tag, "_grant"}, int'(bus.grant_out), (m_src < 0) ? 0 : (1 << m_src));
        chk({tag, "_busy"},  int'(bus.busy_out),
            (m_phase == PH_RISE || m_phase == PH_FALL || m_phase == PH_GAP) ? 1 : 0);
    endtask

    // One sample period of 8 clocks; outputs are looked at on the falling edge after the strobe.
    task automatic strobe();
        repeat (7) @(negedge clk);
        bus.req_in          = cur_req;
        bus.prio_mode_in    = cur_mode;
        bus.audio_in        = cur_aud;
        bus.sample_valid_in = 1'b1;
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
        model_step(cur_req, cur_mode);
        chk("valid_pulse", int'(bus.audio_valid_out), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.sample_valid_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp4_out  [14] = '{32, 32, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0, 0, 1};
    int exp4_gnt  [14] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 1, 1, 1};
    int exp4_busy [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp6_out  [6]  = '{0, 0, 1, 2, 4, 8};

    initial begin
        int gseq[$];
        int last_g;

        bus.sample_valid_in = 1'b0;
        bus.req_in          = 4'd0;
        bus.prio_mode_in    = 1'b0;
        bus.audio_in        = 32'd0;
        model_reset();

        // 1: reset state and idle behaviour
        repeat (3) @(negedge clk);
        chk("rst_out",   int'($signed(bus.audio_out)), 0);
        chk("rst_grant", int'(bus.grant_out), 0);
        chk("rst_busy",  int'(bus.busy_out), 0);
        chk("rst_valid", int'(bus.audio_valid_out), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe();
            chk_model("idle");
        end
        @(negedge clk);
        chk("valid_single", int'(bus.audio_valid_out), 0);

        // 2 and 3: fade-in of +64, then fade-out of -64 to idle
        for (int i = 0; i < 11; i++) tbl.push_back('{4'b0001, 8'd64, (i < 2) ? 0 : ((i < 8) ? (1 << (i - 2)) : 64), 4'b0001, (i < 8) ? 1'b1 : 1'b0});
        tbl.push_back('{4'b0001, 8'hC0, -64, 4'b0001, 1'b0});
        tbl.push_back('{4'b0000, 8'hC0, -32, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0, -16, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,  -8, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,  -4, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,  -2, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,  -1, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,  -1, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,   0, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 8'hC0,   0, 4'b0000, 1'b0});
        tbl.push_back('{4'b0000, 8'hC0,   0, 4'b0000, 1'b0});
        foreach (tbl[i]) begin
            cur_req = tbl[i].req;
            cur_aud = {24'd0, tbl[i].a0};
            strobe();
            chk($sformatf("tbl%0d_out", i),   int'($signed(bus.audio_out)), tbl[i].out);
            chk($sformatf("tbl%0d_grant", i), int'(bus.grant_out), int'(tbl[i].gnt));
            chk($sformatf("tbl%0d_busy", i),  int'(bus.busy_out), int'(tbl[i].busy));
        end

        // 4: fixed-mode preemption waits for the hold time
        cur_mode = 1'b0;
        cur_req  = 4'b0100;
        cur_aud  = {8'h00, 8'h20, 8'h00, 8'h64};
        repeat (10) strobe();
        chk("pre_setup_grant", int'(bus.grant_out), 4);
        chk("pre_setup_out",   int'($signed(bus.audio_out)), 32);
        cur_req = 4'b0101;
        for (int i = 0; i < 14; i++) begin
            strobe();
            chk($sformatf("pre%0d_out", i),   int'($signed(bus.audio_out)), exp4_out[i]);
            chk($sformatf("pre%0d_grant", i), int'(bus.grant_out), exp4_gnt[i]);
            chk($sformatf("pre%0d_busy", i),  int'(bus.busy_out), exp4_busy[i]);
        end

        // 5: round-robin rotation with three steady requesters
        do_reset();
        cur_mode = 1'b1;
        cur_req  = 4'b0111;
        cur_aud  = {4{8'h40}};
        last_g   = 0;
        for (int i = 0; i < 80; i++) begin
            strobe();
            chk_model("rr");
            if (bus.grant_out != 4'd0 && int'(bus.grant_out) != last_g) begin
                last_g = int'(bus.grant_out);
                gseq.push_back(last_g);
            end
        end
        chk("rr_seq_len", (gseq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_seq%0d", i), (i < gseq.size()) ? gseq[i] : -1, (i == 3) ? 1 : (1 << i));

        // 6: reset in the middle of a fade-in
        do_reset();
        cur_mode = 1'b0;
        cur_req  = 4'b0001;
        cur_aud  = {24'd0, 8'd64};
        repeat (5) strobe();
        chk("midfade_out", int'($signed(bus.audio_out)), 4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out",   int'($signed(bus.audio_out)), 0);
        chk("async_rst_grant", int'(bus.grant_out), 0);
        chk("async_rst_busy",  int'(bus.busy_out), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            strobe();
            chk($sformatf("refade%0d_out", i), int'($signed(bus.audio_out)), exp6_out[i]);
        end

        // 7: randomized traffic against the reference model
        do_reset();
        cur_req = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) cur_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
            cur_aud = $urandom;
            strobe();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_channel_arbiter.md
Name: audio_channel_arbiter

Overview:
Shares the single speaker output path (volume control → PWM/PDM) between up to NUM_SRC signed 8-bit audio requesters, such as tone generators, mic passthrough and recorder playback. It picks a winner by fixed priority or round-robin and enforces a minimum hold time. Every source change is sequenced through a shift-based fade-out, a forced silent sample and a fade-in, so switching never clicks. It sits between the audio sources and the volume control, and all state advances on the ~12 kHz sample strobe.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
SAMPLE_W, 8, audio sample width, signed two's complement
MIN_HOLD, 1200, samples a granted source plays before it can be preempted (100 ms at 12 kHz)

Ports:
clk_in  input  1  system clock (98.3 MHz audio clock domain)
rst_in  input  1  asynchronous, active-low reset
sample_valid_in  input  1  single-cycle audio sample strobe (~12 kHz)
req_in  input  NUM_SRC  per-source request level; bit i = source i wants the output
prio_mode_in  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
audio_in  input  NUM_SRC*SAMPLE_W  packed signed samples; source i at bits [i*SAMPLE_W +: SAMPLE_W]
audio_out  output  SAMPLE_W  signed arbitrated and faded sample
audio_valid_out  output  1  single-cycle pulse one clock after sample_valid_in
grant_out  output  NUM_SRC  one-hot current grant; all-zero when none
busy_out  output  1  high in FADE_IN, FADE_OUT and SWITCH

Behaviour:
- Reset (rst_in low, asynchronous):
  - state=IDLE, grant_out=0, atten=8, hold_cnt=0, rr_ptr=0.
  - audio_out=0, audio_valid_out=0, busy_out=0.
- Timing:
  - All registers other than audio_valid_out change only on clock edges where sample_valid_in=1.
  - req_in and audio_in are sampled on that same edge.
  - Latency is 1 clock: audio_out and audio_valid_out are registered.
- Attenuation:
  - atten ranges 0..8; 8 means mute.
  - audio_out = (atten_next==8 || grant_next==0) ? 0 : sel_sample >>> atten_next, where the shift is arithmetic.
  - Negative samples therefore floor: -64>>>7 = -1.
- IDLE:
  - No request: output 0.
  - Any request: load the arbitration winner into grant, keep atten=8, go to FADE_IN. This sample outputs 0.
- FADE_IN:
  - atten-- each sample.
  - When new atten==0: go to PLAY, clear hold_cnt.
  - If the granted req drops: go to FADE_OUT, continuing from the current atten.
- PLAY:
  - hold_cnt++ each sample, saturating at MIN_HOLD.
  - If the granted req drops: go to FADE_OUT immediately, regardless of hold_cnt.
  - Else, if hold_cnt==MIN_HOLD and a preemptor exists: go to FADE_OUT.
    - Fixed mode: a preemptor is any requesting source with a lower index than the current grant.
    - Round-robin mode: a preemptor is any other requesting source.
- FADE_OUT:
  - atten++ each sample.
  - When new atten==8: go to SWITCH. This sample outputs 0 and grant is retained.
- SWITCH (exactly one sample):
  - Clear grant, output 0, then re-arbitrate on the current req_in.
  - Winner found: load grant, go to FADE_IN with atten=8.
  - No winner: go to IDLE.
  - In round-robin mode, a source still requesting may win again if no other source requests.
- Arbitration:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: search starts at rr_ptr and wraps modulo NUM_SRC.
  - rr_ptr = (granted index + 1) mod NUM_SRC, updated whenever a grant is loaded.
- Boundaries:
  - A req change coincident with sample_valid_in is seen on that edge.
  - prio_mode_in changes take effect at the next arbitration or preemption check.
  - Reset mid-fade forces silence immediately; after release the block restarts from IDLE.
  - grant_out is always one-hot or zero.

Decomposition:
- Package audio_arb_pkg holds:
  - state enum {IDLE, FADE_IN, PLAY, FADE_OUT, SWITCH}
  - ATTEN_MUTE = 4'd8
  - ATTEN_W = 4
- Sub-module rr_priority_picker: combinational block.
  - Inputs: req, base index, mode.
  - Outputs: one-hot winner, winner index, found flag.
  - Used both for grant loading and for the preemption check, the latter with the current source masked.

Test Plan (bench sets MIN_HOLD=4, NUM_SRC=4, and strobes sample_valid_in every 8 clocks):
1. Hold rst_in low, then release with req=0 → audio_out=0, grant_out=0000, busy_out=0, audio_valid_out pulses 1 clock after each strobe.
2. Set req=0001 with src0=+64 constant → grant_out=0001, and per-sample outputs are 0,0,1,2,4,8,16,32,64, then steady 64 with busy_out=0.
3. While src0 is playing -64, drop req to 0000 → outputs -32,-16,-8,-4,-2,-1,-1,0 (mute), then 0 in SWITCH with grant_out=0000, then IDLE.
4. Fixed mode with src2 playing and hold_cnt=1: raise req to 0101 → no change until hold_cnt reaches 4, then a fade-out; after SWITCH, grant_out=0001 and src0 fades in.
5. Round-robin mode with req=0111 held constant → grant sequence is 0001, 0010, 0100, 0001, each PLAY lasting 4 samples, with exactly one 0 sample in SWITCH between sources.
6. Assert rst_in low mid-FADE_IN while audio_out=4 → audio_out=0 and grant_out=0000 before the next clock edge; after release, req=0001 gives a fresh fade from 0.
